branch_encoder: RTL and testbench
=================================

Name: branch_encoder

Overview:
- Decodes the RV32I conditional-branch class from the main decoder's Branch strobe and the instruction funct3 field.
- Produces a registered "branch is encoded/valid" flag, a comparison-select code for the branch comparator, and an illegal-branch flag for the trap logic.
- Sits between the instruction decoder and the branch-resolution/PC-select logic.

Parameters:
- SUPPORT_UNSIGNED, 0, when 1 funct3 110 (BLTU) and 111 (BGEU) are accepted; when 0 they are illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Branch  input  1  current instruction is a conditional branch
- funct3  input  3  instruction bits [14:12]
- Encoded_Branch  output  1  registered: valid, supported branch present
- branch_sel  output  2  registered comparison select: 00 EQ, 01 NE, 10 LT, 11 GE
- branch_unsigned  output  1  registered: comparison is unsigned (BLTU/BGEU)
- illegal_branch  output  1  registered: Branch=1 with unsupported funct3

Behaviour:
- Reset: rst_n low asynchronously forces Encoded_Branch=0, branch_sel=00, branch_unsigned=0, illegal_branch=0. Holds while low. Outputs update from the first rising clk edge after release.
- Latency: all outputs are registered. Inputs sampled at rising clk edge N are visible after edge N. No handshake. A new decode occurs every cycle.
- Supported funct3 set:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE.
  - Plus 110 BLTU and 111 BGEU only if SUPPORT_UNSIGNED=1.
  - 010 and 011 are always unsupported.
- Branch=1 with a supported funct3:
  - Encoded_Branch=1.
  - illegal_branch=0.
  - branch_sel={funct3[2],funct3[0]}.
  - branch_unsigned=funct3[1].
- Branch=1 with an unsupported funct3:
  - Encoded_Branch=0.
  - illegal_branch=1.
  - branch_sel=00.
  - branch_unsigned=0.
- Branch=0: all outputs 0 regardless of funct3. illegal_branch is never set without Branch.
- Encoded_Branch and illegal_branch are mutually exclusive in every cycle.
- X or Z on funct3 while Branch=0 must not propagate. Outputs must be 0.
- Reset asserted mid-stream clears the outputs immediately, without waiting for clk. The first decode after release reflects the inputs at that edge only. No history is kept.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 constants F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - branch_sel encodings SEL_EQ/SEL_NE/SEL_LT/SEL_GE.
- Combinational decode plus a single output register stage, kept in one module.
- Optional sub-module branch_decode_comb: purely combinational decode, reused by the bench as a reference model.

Test Plan:
- Reset: hold rst_n=0, Branch=1, funct3=000, toggle clk -> all outputs 0. Release rst_n, next edge -> Encoded_Branch=1, branch_sel=00.
- Branch=0, funct3=000, then funct3=101 -> after each edge Encoded_Branch=0, illegal_branch=0, branch_sel=00.
- Branch=1, funct3=101 (BGE) -> Encoded_Branch=1, branch_sel=11, branch_unsigned=0. Then funct3=001 (BNE) -> Encoded_Branch=1, branch_sel=01.
- Branch=1, funct3=010 -> Encoded_Branch=0, illegal_branch=1, branch_sel=00.
- Branch=1, funct3=111 with SUPPORT_UNSIGNED=0 -> Encoded_Branch=0, illegal_branch=1. With SUPPORT_UNSIGNED=1 -> Encoded_Branch=1, branch_sel=11, branch_unsigned=1.
- Async reset mid-operation: Encoded_Branch=1, drop rst_n between edges -> outputs go 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I branch-decode constants and types.
// Branch funct3 codes and comparator select encodings.
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SEL_EQ = 2'b00,
    SEL_NE = 2'b01,
    SEL_LT = 2'b10,
    SEL_GE = 2'b11
  } branch_sel_e;

  typedef struct packed {
    logic        valid;
    branch_sel_e sel;
    logic        is_unsigned;
    logic        illegal;
  } branch_dec_t;

  localparam branch_dec_t BRANCH_DEC_NONE = '{
    valid:       1'b0,
    sel:         SEL_EQ,
    is_unsigned: 1'b0,
    illegal:     1'b0
  };

  localparam branch_dec_t BRANCH_DEC_ILLEGAL = '{
    valid:       1'b0,
    sel:         SEL_EQ,
    is_unsigned: 1'b0,
    illegal:     1'b1
  };

  function automatic branch_dec_t branch_dec_legal(branch_sel_e sel, logic is_unsigned);
    branch_dec_t d;
    d.valid       = 1'b1;
    d.sel         = sel;
    d.is_unsigned = is_unsigned;
    d.illegal     = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/branch_decode_comb.sv
// Purely combinational RV32I conditional-branch decode.
// Branch gates everything so an unknown funct3 never reaches the outputs when idle.
module branch_decode_comb
  import riscv_pkg::*;
#(
  parameter bit SUPPORT_UNSIGNED = 1'b0
) (
  input  logic        Branch,
  input  logic [2:0]  funct3,
  output branch_dec_t dec
);

  always_comb begin
    dec = BRANCH_DEC_NONE;
    if (Branch) begin
      unique case (funct3)
        F3_BEQ:  dec = branch_dec_legal(SEL_EQ, 1'b0);
        F3_BNE:  dec = branch_dec_legal(SEL_NE, 1'b0);
        F3_BLT:  dec = branch_dec_legal(SEL_LT, 1'b0);
        F3_BGE:  dec = branch_dec_legal(SEL_GE, 1'b0);
        F3_BLTU: dec = SUPPORT_UNSIGNED ? branch_dec_legal(SEL_LT, 1'b1) : BRANCH_DEC_ILLEGAL;
        F3_BGEU: dec = SUPPORT_UNSIGNED ? branch_dec_legal(SEL_GE, 1'b1) : BRANCH_DEC_ILLEGAL;
        default: dec = BRANCH_DEC_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/branch_encoder.sv
// Registered RV32I branch encoder: decode feeds a single output register stage.
// Outputs reflect the inputs sampled at the previous rising clk edge.
module branch_encoder
  import riscv_pkg::*;
#(
  parameter bit SUPPORT_UNSIGNED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Branch,
  input  logic [2:0] funct3,
  output logic       Encoded_Branch,
  output logic [1:0] branch_sel,
  output logic       branch_unsigned,
  output logic       illegal_branch
);

  branch_dec_t dec_d, dec_q;

  branch_decode_comb #(
    .SUPPORT_UNSIGNED(SUPPORT_UNSIGNED)
  ) u_decode (
    .Branch(Branch),
    .funct3(funct3),
    .dec   (dec_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= BRANCH_DEC_NONE;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign Encoded_Branch  = dec_q.valid;
  assign branch_sel      = dec_q.sel;
  assign branch_unsigned = dec_q.is_unsigned;
  assign illegal_branch  = dec_q.illegal;

  // Trap logic relies on never seeing both flags together.
  a_valid_illegal_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(Encoded_Branch && illegal_branch));

endmodule

// File: tb/tb_branch_encoder.sv
// Self-checking bench: both SUPPORT_UNSIGNED builds against an arithmetic reference model.
module tb_branch_encoder;

  logic       clk;
  logic       rst_n;
  logic       Branch;
  logic [2:0] funct3;

  logic       enc0, uns0, ill0;
  logic [1:0] sel0;
  logic       enc1, uns1, ill1;
  logic [1:0] sel1;

  int checks;
  int failures;

  branch_encoder #(.SUPPORT_UNSIGNED(1'b0)) u_dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .Branch         (Branch),
    .funct3         (funct3),
    .Encoded_Branch (enc0),
    .branch_sel     (sel0),
    .branch_unsigned(uns0),
    .illegal_branch (ill0)
  );

  branch_encoder #(.SUPPORT_UNSIGNED(1'b1)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .Branch         (Branch),
    .funct3         (funct3),
    .Encoded_Branch (enc1),
    .branch_sel     (sel1),
    .branch_unsigned(uns1),
    .illegal_branch (ill1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {Encoded_Branch, branch_sel, branch_unsigned, illegal_branch}.
  function automatic logic [4:0] model(logic b, logic [2:0] f, bit su);
    int  v;
    bit  legal;
    logic [1:0] sel;
    v     = int'(f);
    legal = (v == 0) || (v == 1) || (v == 4) || (v == 5) || (su && v >= 6);
    if (!b) return 5'b00000;
    if (!legal) return 5'b00001;
    sel = 2'((v / 4) * 2 + (v % 2));
    return {1'b1, sel, (v >= 6) ? 1'b1 : 1'b0, 1'b0};
  endfunction

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs0();
    return {enc0, sel0, uns0, ill0};
  endfunction

  function automatic logic [4:0] obs1();
    return {enc1, sel1, uns1, ill1};
  endfunction

  // Called at a negedge: drive, let the posedge sample, check at the next negedge.
  task automatic step(input logic b, input logic [2:0] f, input string tag);
    Branch = b;
    funct3 = f;
    @(negedge clk);
    check_eq({tag, "/su0"}, obs0(), model(b, f, 1'b0));
    check_eq({tag, "/su1"}, obs1(), model(b, f, 1'b1));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    Branch   = 1'b1;
    funct3   = 3'b000;

    repeat (3) @(negedge clk);
    check_eq("reset_hold/su0", obs0(), 5'b00000);
    check_eq("reset_hold/su1", obs1(), 5'b00000);

    rst_n = 1'b1;
    @(negedge clk);
    check_eq("first_after_reset/su0", obs0(), 5'b10000);
    check_eq("first_after_reset/su1", obs1(), 5'b10000);

    step(1'b0, 3'b000, "idle_f000");
    step(1'b0, 3'b101, "idle_f101");
    step(1'b1, 3'b101, "bge");
    check_eq("bge_literal", obs0(), 5'b11100);
    step(1'b1, 3'b001, "bne");
    check_eq("bne_literal", obs0(), 5'b10100);
    step(1'b1, 3'b010, "f010");
    check_eq("f010_literal", obs0(), 5'b00001);
    step(1'b1, 3'b011, "f011");
    step(1'b1, 3'b111, "bgeu");
    check_eq("bgeu_su0_literal", obs0(), 5'b00001);
    check_eq("bgeu_su1_literal", obs1(), 5'b11110);
    step(1'b1, 3'b110, "bltu");
    step(1'b1, 3'b100, "blt");
    step(1'b1, 3'b000, "beq");
    step(1'b0, 3'bxxx, "idle_fx");

    // Async reset between edges while a valid branch is registered.
    step(1'b1, 3'b100, "pre_async");
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_clear/su0", obs0(), 5'b00000);
    check_eq("async_clear/su1", obs1(), 5'b00000);
    @(negedge clk);
    check_eq("async_hold/su0", obs0(), 5'b00000);
    rst_n = 1'b1;
    step(1'b1, 3'b111, "post_async");

    for (int i = 0; i < 300; i++) begin
      logic       b;
      logic [2:0] f;
      b = 1'($urandom_range(0, 3) != 0);
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rand_async/su0", obs0(), 5'b00000);
        check_eq("rand_async/su1", obs1(), 5'b00000);
        #1 rst_n = 1'b1;
      end
      step(b, f, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
